// File: rtl/clint_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clint_trap_ctrl
// Description : Core-local interrupt/trap controller. Decodes ecall/ebreak,
//               mret and level interrupt requests at EX, holds the pipeline,
//               writes mepc/mstatus/mcause through the CSR clint port one
//               register per cycle, then redirects the PC to mtvec or mepc.
// Ports       : clk, rst (async active-low)
//               int_flag_i      - level interrupt requests
//               inst_i/inst_addr_i - instruction in EX and its PC
//               jump_flag_i/jump_addr_i - EX redirect in progress
//               hold_flag_i     - pipeline already held elsewhere
//               csr_*_i         - mtvec/mepc/mstatus/MIE from CSR file
//               hold_flag_o     - pipeline stall
//               we_o/waddr_o/raddr_o/data_o - CSR clint write port
//               int_assert_o/int_addr_o     - one-cycle PC redirect
// Revision    : 1.0 - initial release
// ============================================================================
module clint_trap_ctrl #(
    parameter int          INT_NUM   = 8,
    parameter logic [31:0] INT_CAUSE = 32'h8000_0007
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INT_NUM-1:0] int_flag_i,
    input  logic [31:0]        inst_i,
    input  logic [31:0]        inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [31:0]        jump_addr_i,
    input  logic               hold_flag_i,
    input  logic [31:0]        csr_mtvec_i,
    input  logic [31:0]        csr_mepc_i,
    input  logic [31:0]        csr_mstatus_i,
    input  logic               global_int_en_i,
    output logic               hold_flag_o,
    output logic               we_o,
    output logic [31:0]        waddr_o,
    output logic [31:0]        raddr_o,
    output logic [31:0]        data_o,
    output logic               int_assert_o,
    output logic [31:0]        int_addr_o
);

    localparam logic [31:0] c_INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] c_INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] c_INST_MRET   = 32'h3020_0073;

    localparam logic [31:0] c_CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] c_CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] c_CSR_MCAUSE  = 32'h0000_0342;

    localparam logic [31:0] c_CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] c_CAUSE_EBREAK = 32'd3;

    // Each non-IDLE state names the CSR action visible on the registered
    // outputs while the FSM sits in that state.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MSTATUS = 3'd2,
        S_W_MCAUSE  = 3'd3,
        S_ASSERT    = 3'd4,
        S_R_MSTATUS = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_cause;
    logic [31:0] w_cause_nxt;

    logic        r_we;
    logic [31:0] r_waddr;
    logic [31:0] r_data;
    logic        r_int_assert;
    logic [31:0] r_int_addr;

    logic        w_we;
    logic [31:0] w_waddr;
    logic [31:0] w_data;
    logic        w_int_assert;
    logic [31:0] w_int_addr;

    logic        w_idle;
    logic        w_sync_evt;
    logic        w_mret_evt;
    logic        w_async_evt;
    logic        w_accept;
    logic [31:0] w_mstatus_trap;
    logic [31:0] w_mstatus_mret;

    // ------------------------------------------------------------------
    // Event decode. Only meaningful in IDLE; outside IDLE nothing is
    // accepted, which is what makes mid-sequence input changes harmless.
    // ------------------------------------------------------------------
    assign w_idle      = (r_state == S_IDLE);
    assign w_sync_evt  = (inst_i == c_INST_ECALL) || (inst_i == c_INST_EBREAK);
    assign w_mret_evt  = (inst_i == c_INST_MRET);
    assign w_async_evt = (|int_flag_i) && global_int_en_i && !hold_flag_i;
    assign w_accept    = w_idle && (w_sync_evt || w_mret_evt || w_async_evt);

    // Trap entry: MPIE <= MIE, MIE <= 0. Return: MIE <= MPIE, MPIE <= 1.
    always_comb begin
        w_mstatus_trap    = csr_mstatus_i;
        w_mstatus_trap[7] = csr_mstatus_i[3];
        w_mstatus_trap[3] = 1'b0;
        w_mstatus_mret    = csr_mstatus_i;
        w_mstatus_mret[3] = csr_mstatus_i[7];
        w_mstatus_mret[7] = 1'b1;
    end

    // The stall must be combinational so the trapping instruction is held
    // in EX during its own acceptance cycle. Gated by reset so every output
    // reads 0 while reset is asserted.
    assign hold_flag_o = rst && (!w_idle || w_accept);

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Outputs are computed for the
    // state being entered and registered, so each state presents its own
    // CSR write / redirect.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_cause_nxt  = r_cause;
        w_we         = 1'b0;
        w_waddr      = 32'h0;
        w_data       = 32'h0;
        w_int_assert = 1'b0;
        w_int_addr   = 32'h0;

        case (r_state)
            S_IDLE: begin
                if (w_sync_evt) begin
                    w_next_state = S_W_MEPC;
                    w_cause_nxt  = (inst_i == c_INST_ECALL) ? c_CAUSE_ECALL
                                                            : c_CAUSE_EBREAK;
                    w_we         = 1'b1;
                    w_waddr      = c_CSR_MEPC;
                    // Synchronous traps resume after the trapping instruction.
                    w_data       = inst_addr_i + 32'd4;
                end else if (w_mret_evt) begin
                    w_next_state = S_R_MSTATUS;
                    w_we         = 1'b1;
                    w_waddr      = c_CSR_MSTATUS;
                    w_data       = w_mstatus_mret;
                end else if (w_async_evt) begin
                    w_next_state = S_W_MEPC;
                    w_cause_nxt  = INT_CAUSE;
                    w_we         = 1'b1;
                    w_waddr      = c_CSR_MEPC;
                    // A redirect in flight must not be lost: resume at its
                    // target rather than at the instruction in EX.
                    w_data       = jump_flag_i ? jump_addr_i : inst_addr_i;
                end
            end
            S_W_MEPC: begin
                w_next_state = S_W_MSTATUS;
                w_we         = 1'b1;
                w_waddr      = c_CSR_MSTATUS;
                w_data       = w_mstatus_trap;
            end
            S_W_MSTATUS: begin
                w_next_state = S_W_MCAUSE;
                w_we         = 1'b1;
                w_waddr      = c_CSR_MCAUSE;
                w_data       = r_cause;
            end
            S_W_MCAUSE: begin
                w_next_state = S_ASSERT;
                w_int_assert = 1'b1;
                w_int_addr   = csr_mtvec_i;
            end
            S_R_MSTATUS: begin
                w_next_state = S_ASSERT;
                w_int_assert = 1'b1;
                w_int_addr   = csr_mepc_i;
            end
            S_ASSERT: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cause      <= 32'h0;
            r_we         <= 1'b0;
            r_waddr      <= 32'h0;
            r_data       <= 32'h0;
            r_int_assert <= 1'b0;
            r_int_addr   <= 32'h0;
        end else begin
            r_state      <= w_next_state;
            r_cause      <= w_cause_nxt;
            r_we         <= w_we;
            r_waddr      <= w_waddr;
            r_data       <= w_data;
            r_int_assert <= w_int_assert;
            r_int_addr   <= w_int_addr;
        end
    end

    assign we_o         = r_we;
    assign waddr_o      = r_waddr;
    assign data_o       = r_data;
    assign int_assert_o = r_int_assert;
    assign int_addr_o   = r_int_addr;
    assign raddr_o      = 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_clint_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clint_trap_ctrl
// Description : Self-checking bench for clint_trap_ctrl. A reference model
//               turns each accepted event into a queue of expected per-cycle
//               CSR-port / redirect values; directed scenarios are followed
//               by randomized stimulus with occasional mid-run resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clint_trap_ctrl;

    localparam int          INT_NUM   = 8;
    localparam logic [31:0] INT_CAUSE = 32'h8000_0007;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic               clk;
    logic               rst;
    logic [INT_NUM-1:0] int_flag_i;
    logic [31:0]        inst_i;
    logic [31:0]        inst_addr_i;
    logic               jump_flag_i;
    logic [31:0]        jump_addr_i;
    logic               hold_flag_i;
    logic [31:0]        csr_mtvec_i;
    logic [31:0]        csr_mepc_i;
    logic [31:0]        csr_mstatus_i;
    logic               global_int_en_i;
    logic               hold_flag_o;
    logic               we_o;
    logic [31:0]        waddr_o;
    logic [31:0]        raddr_o;
    logic [31:0]        data_o;
    logic               int_assert_o;
    logic [31:0]        int_addr_o;

    clint_trap_ctrl #(
        .INT_NUM   (INT_NUM),
        .INT_CAUSE (INT_CAUSE)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .int_flag_i      (int_flag_i),
        .inst_i          (inst_i),
        .inst_addr_i     (inst_addr_i),
        .jump_flag_i     (jump_flag_i),
        .jump_addr_i     (jump_addr_i),
        .hold_flag_i     (hold_flag_i),
        .csr_mtvec_i     (csr_mtvec_i),
        .csr_mepc_i      (csr_mepc_i),
        .csr_mstatus_i   (csr_mstatus_i),
        .global_int_en_i (global_int_en_i),
        .hold_flag_o     (hold_flag_o),
        .we_o            (we_o),
        .waddr_o         (waddr_o),
        .raddr_o         (raddr_o),
        .data_o          (data_o),
        .int_assert_o    (int_assert_o),
        .int_addr_o      (int_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output picture for one future cycle.
    typedef struct packed {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] data;
        logic        as;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_traps = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic exp_t mk(input logic we, input logic [31:0] wa, input logic [31:0] d,
                                input logic as, input logic [31:0] ad);
        exp_t e;
        e.we = we; e.waddr = wa; e.data = d; e.as = as; e.addr = ad;
        return e;
    endfunction

    // Reference model: given this cycle's inputs in an idle cycle, decide
    // whether an event is taken and schedule its effects on later cycles.
    function automatic bit model_accept();
        logic [31:0] ms;
        logic [31:0] epc;
        logic [31:0] cause;
        bit          take_trap;
        take_trap = 1'b0;
        epc       = 32'h0;
        cause     = 32'h0;
        if (inst_i == ECALL || inst_i == EBREAK) begin
            take_trap = 1'b1;
            epc       = inst_addr_i + 32'd4;
            cause     = (inst_i == ECALL) ? 32'd11 : 32'd3;
        end else if (inst_i == MRET) begin
            ms    = csr_mstatus_i;
            ms[3] = csr_mstatus_i[7];
            ms[7] = 1'b1;
            exp_q.push_back(mk(1'b1, 32'h300, ms, 1'b0, 32'h0));
            exp_q.push_back(mk(1'b0, 32'h0, 32'h0, 1'b1, csr_mepc_i));
            return 1'b1;
        end else if ((int_flag_i != '0) && global_int_en_i && !hold_flag_i) begin
            take_trap = 1'b1;
            epc       = jump_flag_i ? jump_addr_i : inst_addr_i;
            cause     = INT_CAUSE;
        end
        if (!take_trap) return 1'b0;
        ms    = csr_mstatus_i;
        ms[7] = csr_mstatus_i[3];
        ms[3] = 1'b0;
        exp_q.push_back(mk(1'b1, 32'h341, epc, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b1, 32'h300, ms, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b1, 32'h342, cause, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b0, 32'h0, 32'h0, 1'b1, csr_mtvec_i));
        return 1'b1;
    endfunction

    // Called just after a rising edge with inputs already driven. Optionally
    // pulses reset inside the cycle, checks at the falling edge, and returns
    // just after the next rising edge with reset released.
    task automatic check_cycle(input bit pulse_rst);
        exp_t e;
        bit   busy;
        bit   acc;
        if (pulse_rst) begin
            rst = 1'b0;
            exp_q.delete();
        end
        @(negedge clk);
        if (!rst) begin
            chk("rst_we",     {31'h0, we_o},         32'h0);
            chk("rst_waddr",  waddr_o,               32'h0);
            chk("rst_data",   data_o,                32'h0);
            chk("rst_assert", {31'h0, int_assert_o}, 32'h0);
            chk("rst_addr",   int_addr_o,            32'h0);
            chk("rst_hold",   {31'h0, hold_flag_o},  32'h0);
            chk("rst_raddr",  raddr_o,               32'h0);
        end else begin
            busy = (exp_q.size() != 0);
            e    = busy ? exp_q.pop_front() : '0;
            chk("we",       {31'h0, we_o},         {31'h0, e.we});
            chk("waddr",    waddr_o,               e.waddr);
            chk("data",     data_o,                e.data);
            chk("int_assert", {31'h0, int_assert_o}, {31'h0, e.as});
            chk("int_addr", int_addr_o,            e.addr);
            chk("raddr",    raddr_o,               32'h0);
            acc = busy ? 1'b0 : model_accept();
            if (acc) n_traps++;
            chk("hold", {31'h0, hold_flag_o}, {31'h0, (busy || acc)});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic set_quiet();
        int_flag_i      = '0;
        inst_i          = NOP;
        inst_addr_i     = 32'h0;
        jump_flag_i     = 1'b0;
        jump_addr_i     = 32'h0;
        hold_flag_i     = 1'b0;
        global_int_en_i = 1'b0;
    endtask

    task automatic run_quiet(input int n);
        for (int i = 0; i < n; i++) check_cycle(1'b0);
    endtask

    initial begin
        rst           = 1'b0;
        csr_mtvec_i   = 32'h0;
        csr_mepc_i    = 32'h0;
        csr_mstatus_i = 32'h0;
        set_quiet();
        #1;
        check_cycle(1'b0);            // reset state

        // ecall at 0x100 -> mepc 0x104, mstatus 0x80, mcause 11, redirect 0x200
        csr_mtvec_i = 32'h200; csr_mstatus_i = 32'h8; global_int_en_i = 1'b1;
        inst_i = ECALL; inst_addr_i = 32'h100;
        check_cycle(1'b0);
        inst_i = NOP;
        run_quiet(5);

        // interrupt during EX redirect -> mepc = jump target
        int_flag_i = 8'h01; inst_addr_i = 32'h40; jump_flag_i = 1'b1; jump_addr_i = 32'h80;
        check_cycle(1'b0);
        int_flag_i = '0; jump_flag_i = 1'b0;
        run_quiet(5);

        // interrupt masked by MIE, then by an external hold
        int_flag_i = 8'h01; global_int_en_i = 1'b0;
        run_quiet(2);
        global_int_en_i = 1'b1; hold_flag_i = 1'b1;
        run_quiet(2);
        int_flag_i = '0; hold_flag_i = 1'b0;

        // mret with mstatus 0x80, mepc 0x104
        csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
        inst_i = MRET;
        check_cycle(1'b0);
        inst_i = NOP;
        run_quiet(3);

        // ecall wins over a simultaneous interrupt; interrupt waits for MIE
        csr_mstatus_i = 32'h8; global_int_en_i = 1'b1;
        inst_i = ECALL; inst_addr_i = 32'h300; int_flag_i = 8'h10;
        check_cycle(1'b0);
        inst_i = NOP; global_int_en_i = 1'b0;
        run_quiet(7);
        inst_i = MRET;
        check_cycle(1'b0);
        inst_i = NOP; global_int_en_i = 1'b1;
        run_quiet(8);
        int_flag_i = '0;
        run_quiet(2);

        // wrap of inst_addr + 4
        inst_i = EBREAK; inst_addr_i = 32'hFFFF_FFFC;
        check_cycle(1'b0);
        inst_i = NOP;
        run_quiet(5);

        // reset pulsed in W_MSTATUS: no redirect afterwards
        inst_i = ECALL; inst_addr_i = 32'h500;
        check_cycle(1'b0);            // accept
        inst_i = NOP;
        check_cycle(1'b0);            // W_MEPC
        check_cycle(1'b1);            // W_MSTATUS with reset
        run_quiet(5);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       inst_i = ECALL;
                1:       inst_i = EBREAK;
                2:       inst_i = MRET;
                default: inst_i = $urandom;
            endcase
            inst_addr_i     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            int_flag_i      = ($urandom_range(0, 1) == 0) ? '0 : INT_NUM'($urandom);
            jump_flag_i     = 1'($urandom);
            jump_addr_i     = $urandom;
            hold_flag_i     = ($urandom_range(0, 3) == 0);
            global_int_en_i = 1'($urandom);
            // CSR values only move between sequences, as a real CSR file
            // would only change under the controller's own writes then.
            if (exp_q.size() == 0) begin
                csr_mtvec_i   = $urandom;
                csr_mepc_i    = $urandom;
                csr_mstatus_i = $urandom;
            end
            check_cycle($urandom_range(0, 49) == 0);
        end

        if (n_traps < 50) chk("event_coverage", n_traps, 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clint_trap_ctrl.md
Name: clint_trap_ctrl

Overview:
- Core-local interrupt/trap controller. Sits beside the CSR file and is its only non-EX writer.
- Detects ecall/ebreak, mret and external interrupt lines at the EX stage, and holds the pipeline while it runs the trap or return sequence.
- Writes mepc/mstatus/mcause through the CSR file's clint write port, then redirects the PC to mtvec or mepc.

Parameters:
- INT_NUM, 8: number of interrupt request lines.
- INT_CAUSE, 32'h8000_0007: mcause value written for any asynchronous interrupt.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- int_flag_i  in  INT_NUM  level interrupt requests; any bit set = pending.
- inst_i  in  32  instruction currently in EX.
- inst_addr_i  in  32  PC of inst_i.
- jump_flag_i  in  1  EX is redirecting this cycle.
- jump_addr_i  in  32  EX redirect target.
- hold_flag_i  in  1  pipeline already held by another source.
- csr_mtvec_i  in  32  mtvec from CSR file.
- csr_mepc_i  in  32  mepc from CSR file.
- csr_mstatus_i  in  32  mstatus from CSR file.
- global_int_en_i  in  1  mstatus.MIE from CSR file.
- hold_flag_o  out  1  stall whole pipeline.
- we_o  out  1  CSR write enable (clint port).
- waddr_o  out  32  CSR write address.
- raddr_o  out  32  CSR read address; constant 0.
- data_o  out  32  CSR write data.
- int_assert_o  out  1  one-cycle PC redirect strobe.
- int_addr_o  out  32  redirect target.

Behaviour:
- Reset (rst low, async): state=IDLE, every output 0, latched cause/epc registers 0.
- Decode (combinational, IDLE only):
  - sync_evt: inst_i == 32'h0000_0073 (ecall, cause 11) or 32'h0010_0073 (ebreak, cause 3).
  - mret_evt: inst_i == 32'h3020_0073.
  - async_evt: |int_flag_i && global_int_en_i && !hold_flag_i.
- Priority: sync > mret > async. Only one event accepted per cycle; losers are ignored. A level interrupt is re-evaluated when the FSM returns to IDLE.
- EPC latched on acceptance:
  - sync: inst_addr_i + 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000).
  - async: jump_flag_i ? jump_addr_i : inst_addr_i.
- hold_flag_o = (state != IDLE) OR (an event is accepted this cycle). Combinational, so the trapping instruction never retires past EX.
- Trap sequence, registered outputs, one CSR write per cycle:
  - IDLE -> W_MEPC: we_o=1, waddr_o=0x341, data_o=epc.
  - -> W_MSTATUS: waddr_o=0x300, data_o = csr_mstatus_i with bit7 (MPIE) = bit3 (old MIE) and bit3 = 0.
  - -> W_MCAUSE: waddr_o=0x342, data_o=cause.
  - -> ASSERT: we_o=0, int_assert_o=1, int_addr_o=csr_mtvec_i.
  - -> IDLE.
- Mret sequence:
  - IDLE -> R_MSTATUS: we_o=1, waddr_o=0x300, data_o = csr_mstatus_i with bit3 = bit7 and bit7 = 1.
  - -> ASSERT: int_assert_o=1, int_addr_o=csr_mepc_i.
  - -> IDLE.
- Latency from acceptance cycle to int_assert_o: trap = 4 cycles, mret = 2 cycles.
- int_assert_o is high for exactly one cycle. In every cycle without a write, we_o=0 and waddr_o/data_o=0. int_addr_o=0 except in ASSERT.
- Because the FSM is never in IDLE mid-sequence, inputs changing during a sequence have no effect. This includes int_flag_i, inst_i and a second ecall.
- MIE is cleared by the W_MSTATUS write, so no nested interrupt is taken after a trap until mret restores it.
- Reset asserted mid-sequence: immediate return to IDLE, all outputs 0, partially written CSRs left as-is. The CSR file is reset by the same reset.
- The EX CSR write has priority in the CSR file. The controller's hold stalls EX, so there is no collision by construction; no retry logic.

Test Plan:
- ecall at PC 0x100, mtvec=0x200, mstatus=0x8 -> writes mepc=0x104, mstatus=0x80, mcause=11 on consecutive cycles; int_assert_o=1 with int_addr_o=0x200 in the 4th cycle; hold_flag_o high for all 4 cycles.
- int_flag_i=8'h01, MIE=1, inst_addr_i=0x40, jump_flag_i=1, jump_addr_i=0x80 -> mepc=0x80, mcause=0x8000_0007, redirect to mtvec.
- Same interrupt with MIE=0, or with hold_flag_i=1 -> no write, hold_flag_o=0.
- mret with mstatus=0x80, mepc=0x104 -> mstatus write 0x88; then int_assert_o=1, int_addr_o=0x104; 2 cycles total.
- ecall with int_flag_i asserted in the same cycle -> cause 11 taken; interrupt not accepted until after mret.
- rst pulsed low during W_MSTATUS -> outputs 0 immediately; state is IDLE after release; int_assert_o never fires.
